// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
// Shares one i2c_trans write master among N_REQ requesters. It picks a pending
// request, latches that requester's register word and pulses a start. It then
// follows the master's ready handshake and returns done/error to the winner.
// Optional feature macro: I2C_ARB_RR_EN. When it is defined, arbitration is
// round-robin. When it is undefined, arbitration is fixed priority and the
// lowest index wins.
`timescale 1ns/1ps
module i2c_req_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 16,
    parameter int BUSY_TMO = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_done,
    output logic                      o_err,
    output logic                      o_busy,
    output logic                      o_start,
    output logic [DATA_W-1:0]         o_reg_data,
    input  logic                      i_ready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TMO + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TMO);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]        r_state;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_done;
    logic              r_err;
    logic              r_busy;
    logic              r_start;
    logic [DATA_W-1:0] r_reg_data;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_found;
    logic [IDX_W-1:0]  w_win;

`ifdef I2C_ARB_RR_EN
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_win;

    // Round-robin winner: scan upward from the slot after the last winner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_ptr) + i) % N_REQ);
            end
        end
    end
`else
    // Fixed-priority winner: the lowest pending index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(i);
            end
        end
    end
`endif

    // Transaction sequencer. Every output is a register, so no input reaches an output combinationally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_reg_data <= '0;
            r_cnt      <= '0;
`ifdef I2C_ARB_RR_EN
            r_ptr      <= IDX_W'(N_REQ - 1);
            r_win      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ready && w_found) begin
                        r_state    <= S_START;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_gnt      <= ONE_HOT0 << w_win;
                        r_reg_data <= i_data[int'(w_win)*DATA_W +: DATA_W];
`ifdef I2C_ARB_RR_EN
                        r_win      <= w_win;
`endif
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!i_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= S_DONE;
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_ready) begin
                        r_state <= S_DONE;
                        r_done  <= r_gnt;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
`ifdef I2C_ARB_RR_EN
                    r_ptr   <= r_win;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_busy     = r_busy;
    assign o_start    = r_start;
    assign o_reg_data = r_reg_data;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter
// Randomized bench for i2c_req_arbiter. It plays the role of the requesters and
// of the i2c_trans master. From the arbitration rules and handshake timing, it
// predicts on which cycle each output should change.
// It follows I2C_ARB_RR_EN in the same way as the design.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;

    localparam int N_REQ    = 3;
    localparam int DATA_W   = 16;
    localparam int BUSY_TMO = 8;
    localparam int BW       = 2*N_REQ + 3 + DATA_W;

    logic                    i_clk   = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic [N_REQ-1:0]        i_req   = '0;
    logic [N_REQ*DATA_W-1:0] i_data  = '0;
    logic                    i_ready = 1'b1;
    logic [N_REQ-1:0]        o_gnt;
    logic [N_REQ-1:0]        o_done;
    logic                    o_err;
    logic                    o_busy;
    logic                    o_start;
    logic [DATA_W-1:0]       o_reg_data;
    logic [BW-1:0]           obs;

    int checkCount = 0;
    int errorCount = 0;
    int modelPtr   = N_REQ - 1;
    logic [DATA_W-1:0] lastData = '0;

    i2c_req_arbiter #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .BUSY_TMO (BUSY_TMO)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_busy     (o_busy),
        .o_start    (o_start),
        .o_reg_data (o_reg_data),
        .i_ready    (i_ready)
    );

    assign obs = {o_gnt, o_done, o_err, o_busy, o_start, o_reg_data};

    // Free-running 100 MHz clock
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got {gnt,done,err,busy,start,data}=%0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [BW-1:0] pack(input logic [N_REQ-1:0] gnt, input logic [N_REQ-1:0] done,
                                           input logic err, input logic busy, input logic start,
                                           input logic [DATA_W-1:0] data);
        return {gnt, done, err, busy, start, data};
    endfunction

    function automatic int pickWinner(input logic [N_REQ-1:0] req);
`ifdef I2C_ARB_RR_EN
        for (int i = 1; i <= N_REQ; i++)
            if (req[(modelPtr + i) % N_REQ]) return (modelPtr + i) % N_REQ;
`else
        for (int i = 0; i < N_REQ; i++)
            if (req[i]) return i;
`endif
        return -1;
    endfunction

    function automatic logic [N_REQ*DATA_W-1:0] randomData();
        logic [N_REQ*DATA_W-1:0] d;
        for (int k = 0; k < N_REQ; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return d;
    endfunction

    task automatic idleCycles(input int n);
        i_req = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            checkOutput("idle", obs, pack('0, '0, 1'b0, 1'b0, 1'b0, lastData));
        end
    endtask

    // One transaction, entered and left at the falling edge of an IDLE cycle.
    // fallDelay 0 means the master never goes busy, so the transaction times out.
    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ*DATA_W-1:0] data,
                                 input int holdOff, input int fallDelay, input int lowLen,
                                 input bit midChange, input logic [N_REQ-1:0] midReq, input bit doReset);
        int win;
        int doneAt;
        bit tmo;
        logic [N_REQ-1:0] oh;
        logic [DATA_W-1:0] word;
        i_req   = req;
        i_data  = data;
        i_ready = (holdOff == 0);
        for (int c = 0; c < holdOff; c++) begin
            @(negedge i_clk);
            checkOutput("held_off_while_master_busy", obs, pack('0, '0, 1'b0, 1'b0, 1'b0, lastData));
            if (c == holdOff - 1) i_ready = 1'b1;
        end
        win  = pickWinner(req);
        oh   = N_REQ'(1) << win;
        word = data[win*DATA_W +: DATA_W];
        @(negedge i_clk);
        checkOutput("start", obs, pack(oh, '0, 1'b0, 1'b1, 1'b1, word));
        lastData = word;
        tmo    = (fallDelay == 0);
        doneAt = tmo ? BUSY_TMO + 2 : fallDelay + lowLen + 1;
        for (int t = 1; t <= doneAt; t++) begin
            @(negedge i_clk);
            if (t < doneAt)
                checkOutput("in_flight", obs, pack(oh, '0, 1'b0, 1'b1, 1'b0, word));
            else
                checkOutput(tmo ? "done_timeout" : "done", obs, pack(oh, oh, tmo, 1'b1, 1'b0, word));
            i_ready = !(!tmo && t >= fallDelay && t < fallDelay + lowLen);
            if (midChange && t == (tmo ? 1 : fallDelay + 1)) i_req = midReq;
            if (doReset && !tmo && t == fallDelay + 1) begin
                i_rst_n = 1'b0;
                #1;
                checkOutput("async_reset", obs, pack('0, '0, 1'b0, 1'b0, 1'b0, '0));
                modelPtr = N_REQ - 1;
                lastData = '0;
                i_ready  = 1'b1;
                i_req    = '0;
                @(negedge i_clk);
                checkOutput("in_reset_no_done", obs, pack('0, '0, 1'b0, 1'b0, 1'b0, '0));
                i_rst_n = 1'b1;
                return;
            end
        end
        modelPtr = win;
        i_ready  = 1'b1;
        @(negedge i_clk);
        checkOutput("back_to_idle", obs, pack('0, '0, 1'b0, 1'b0, 1'b0, word));
    endtask

    initial begin
        logic [N_REQ*DATA_W-1:0] d;
        logic [N_REQ-1:0]        rq;
        int                      fall;

        repeat (2) @(negedge i_clk);
        checkOutput("reset_values", obs, pack('0, '0, 1'b0, 1'b0, 1'b0, '0));
        i_rst_n = 1'b1;
        idleCycles(2);

        // Single request from the configuration sequencer
        d = randomData();
        d[0 +: DATA_W] = 16'h1E00;
        applyStimulus(3'b001, d, 0, 1, 40, 1'b0, '0, 1'b0);

        // Two requesters held high across four transactions
        d = randomData();
        d[0 +: DATA_W]      = 16'h0C10;
        d[DATA_W +: DATA_W] = 16'h0579;
        for (int n = 0; n < 4; n++) applyStimulus(3'b011, d, 0, 2, 5, 1'b0, '0, 1'b0);
        idleCycles(1);

        // Master never goes busy, then a normal transaction follows
        applyStimulus(3'b001, randomData(), 0, 0, 1, 1'b0, '0, 1'b0);
        applyStimulus(3'b001, randomData(), 0, 3, 4, 1'b0, '0, 1'b0);

        // Request arrives while the master is still busy
        applyStimulus(3'b010, randomData(), 3, 1, 6, 1'b0, '0, 1'b0);

        // Requester withdraws during WAIT_DONE
        applyStimulus(3'b010, randomData(), 0, 2, 6, 1'b1, 3'b000, 1'b0);
        idleCycles(1);

        // Reset in WAIT_DONE, then all requesters compete
        applyStimulus(3'b010, randomData(), 0, 2, 6, 1'b0, '0, 1'b1);
        applyStimulus(3'b111, randomData(), 0, 1, 3, 1'b0, '0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) idleCycles($urandom_range(1, 3));
            rq   = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            fall = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, BUSY_TMO);
            applyStimulus(rq, randomData(), $urandom_range(0, 2), fall, $urandom_range(1, 6),
                          1'($urandom_range(0, 1)), N_REQ'($urandom), $urandom_range(0, 19) == 0);
        end
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
